// File: rtl/orion_types.sv
// Shared decode-stage types: opcode map, decoded-instruction register layout,
// forwarding-source bundle.
package orion_types;

   localparam int XLEN_DEFAULT      = 32;
   localparam int NREG_BITS_DEFAULT = 5;
   localparam int NUM_FWD_DEFAULT   = 2;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_OP_REG = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [3:0] {
      OPC_NONE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP_REG, OPC_FENCE, OPC_SYSTEM
   } op_class_t;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0]      pc;
      logic [XLEN_DEFAULT-1:0]      rs1_v;
      logic [XLEN_DEFAULT-1:0]      rs2_v;
      logic [XLEN_DEFAULT-1:0]      imm;
      logic [NREG_BITS_DEFAULT-1:0] rd_s;
      logic [NREG_BITS_DEFAULT-1:0] rs1_s;
      logic [NREG_BITS_DEFAULT-1:0] rs2_s;
      logic [2:0]                   funct3;
      logic                         alt;
      op_class_t                    op;
      logic                         rd_we;
      logic                         is_load;
      logic                         is_store;
      logic                         illegal;
   } id_ex_t;

   typedef struct packed {
      logic                         valid;
      logic                         rd_we;
      logic [NREG_BITS_DEFAULT-1:0] rd_s;
      logic [XLEN_DEFAULT-1:0]      rd_v;
      logic                         pending;
   } fwd_src_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder: instruction word to id_ex_t control fields
// plus operand-use flags. Operand values and pc are left zero for the caller.
module instr_decoder
   import orion_types::*;
(
   input  logic [31:0] instr,
   output id_ex_t      ctl,
   output logic        uses_rs1,
   output logic        uses_rs2
);

   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        bad, writes;

   assign f3    = instr[14:12];
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      ctl        = '0;
      ctl.rd_s   = instr[11:7];
      ctl.rs1_s  = instr[19:15];
      ctl.rs2_s  = instr[24:20];
      ctl.funct3 = f3;
      uses_rs1   = 1'b0;
      uses_rs2   = 1'b0;
      bad        = 1'b0;
      writes     = 1'b0;
      case (instr[6:0])
         OP_LUI:    begin ctl.op = OPC_LUI;   ctl.imm = imm_u; writes = 1'b1; end
         OP_AUIPC:  begin ctl.op = OPC_AUIPC; ctl.imm = imm_u; writes = 1'b1; end
         OP_JAL:    begin ctl.op = OPC_JAL;   ctl.imm = imm_j; writes = 1'b1; end
         OP_JALR: begin
            ctl.op = OPC_JALR; ctl.imm = imm_i; writes = 1'b1; uses_rs1 = 1'b1;
            bad = (f3 != 3'b000);
         end
         OP_BRANCH: begin
            ctl.op = OPC_BRANCH; ctl.imm = imm_b; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            bad = (f3[2:1] == 2'b01);
         end
         OP_LOAD: begin
            ctl.op = OPC_LOAD; ctl.imm = imm_i; writes = 1'b1; uses_rs1 = 1'b1;
            bad = (f3 == 3'b011) | (f3[2:1] == 2'b11);
         end
         OP_STORE: begin
            ctl.op = OPC_STORE; ctl.imm = imm_s; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            bad = (f3 > 3'b010);
         end
         OP_OP_IMM: begin
            ctl.op = OPC_OP_IMM; ctl.imm = imm_i; writes = 1'b1; uses_rs1 = 1'b1;
            ctl.alt = (f3 == 3'b101) & instr[30];
         end
         OP_OP_REG: begin
            ctl.op = OPC_OP_REG; writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            ctl.alt = instr[30];
         end
         // Only plain FENCE and ECALL/EBREAK belong to the base set.
         OP_FENCE:  begin ctl.op = OPC_FENCE;  ctl.imm = imm_i; bad = (f3 != 3'b000); end
         OP_SYSTEM: begin ctl.op = OPC_SYSTEM; ctl.imm = imm_i; bad = (f3 != 3'b000); end
         default:   bad = 1'b1;
      endcase
      ctl.illegal  = bad;
      ctl.rd_we    = writes & ~bad;
      ctl.is_load  = (ctl.op == OPC_LOAD)  & ~bad;
      ctl.is_store = (ctl.op == OPC_STORE) & ~bad;
   end

endmodule

// File: rtl/decode_pipe.sv
// Registered RV32I decode stage: operand forwarding, load-use stall, flush.
// Optional DECODE_PERF_CNT_EN adds stall/bubble performance counters.
module decode_pipe
   import orion_types::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int NUM_FWD   = NUM_FWD_DEFAULT,
   parameter int NREG_BITS = NREG_BITS_DEFAULT
)(
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         if_valid_i,
   output logic                         if_ready_o,
   input  logic [31:0]                  if_instr_i,
   input  logic [XLEN-1:0]              if_pc_i,
   output logic [NREG_BITS-1:0]         rf_rs1_s_o,
   output logic [NREG_BITS-1:0]         rf_rs2_s_o,
   input  logic [XLEN-1:0]              rf_rs1_v_i,
   input  logic [XLEN-1:0]              rf_rs2_v_i,
   input  logic [NUM_FWD-1:0]           fwd_valid_i,
   input  logic [NUM_FWD-1:0]           fwd_rd_we_i,
   input  logic [NUM_FWD*NREG_BITS-1:0] fwd_rd_s_i,
   input  logic [NUM_FWD*XLEN-1:0]      fwd_rd_v_i,
   input  logic [NUM_FWD-1:0]           fwd_pending_i,
   output logic [$bits(id_ex_t)-1:0]    id_ex_o,
   output logic                         id_valid_o,
   input  logic                         ex_ready_i
`ifdef DECODE_PERF_CNT_EN
  ,output logic [31:0]                  stall_cnt_o,
   output logic [31:0]                  bubble_cnt_o
`endif
);

   id_ex_t                      dec, nxt, id_ex_q;
   logic                        uses_rs1, uses_rs2;
   logic [1:0][NREG_BITS-1:0]   rs_s;
   logic [1:0][XLEN-1:0]        rf_v, op_v;
   logic [1:0]                  op_pend;
   logic                        adv, hz, load;

   instr_decoder u_dec (
      .instr    (if_instr_i),
      .ctl      (dec),
      .uses_rs1 (uses_rs1),
      .uses_rs2 (uses_rs2)
   );

   assign rs_s[0]    = if_instr_i[15 +: NREG_BITS];
   assign rs_s[1]    = if_instr_i[20 +: NREG_BITS];
   assign rf_v[0]    = rf_rs1_v_i;
   assign rf_v[1]    = rf_rs2_v_i;
   assign rf_rs1_s_o = rs_s[0];
   assign rf_rs2_s_o = rs_s[1];

   // Scan oldest to youngest so the youngest match overwrites; x0 overrides all.
   always_comb begin
      op_v    = rf_v;
      op_pend = '0;
      for (int r = 0; r < 2; r++) begin
         for (int k = NUM_FWD-1; k >= 0; k--) begin
            if (fwd_valid_i[k] && fwd_rd_we_i[k] &&
                rs_s[r] == fwd_rd_s_i[k*NREG_BITS +: NREG_BITS]) begin
               op_v[r]    = fwd_rd_v_i[k*XLEN +: XLEN];
               op_pend[r] = fwd_pending_i[k];
            end
         end
         if (rs_s[r] == '0) begin
            op_v[r]    = '0;
            op_pend[r] = 1'b0;
         end
      end
   end

   assign adv        = ~id_valid_o | ex_ready_i;
   assign hz         = if_valid_i & ((uses_rs1 & op_pend[0]) | (uses_rs2 & op_pend[1]));
   assign load       = if_valid_i & ~hz;
   assign if_ready_o = flush_i | (adv & ~hz);

   always_comb begin
      nxt       = dec;
      nxt.pc    = if_pc_i;
      nxt.rs1_v = op_v[0];
      nxt.rs2_v = op_v[1];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         id_valid_o <= 1'b0;
         id_ex_q    <= '0;
      end else if (flush_i) begin
         id_valid_o <= 1'b0;
      end else if (adv) begin
         id_valid_o <= load;
         if (load) id_ex_q <= nxt;
      end
   end

   assign id_ex_o = id_ex_q;

`ifdef DECODE_PERF_CNT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_o  <= '0;
         bubble_cnt_o <= '0;
      end else begin
         if (hz & adv)                  stall_cnt_o  <= stall_cnt_o + 32'd1;
         if (adv & (flush_i | ~load))   bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
   end
`endif

endmodule
